// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO and launch sequencer sitting directly in front of the UART
//   transmitter. Producers push bytes with a single-cycle write strobe; the
//   block drains the FIFO one byte at a time into the transmitter, pacing
//   itself on the transmitter's busy flag.
//
// Ports
//   i_Clock      system clock, all logic on the rising edge
//   i_Reset      synchronous, active-high reset
//   i_Wr_En      push i_Wr_Data this cycle
//   i_Wr_Data    byte to queue
//   o_Full       FIFO holds 2**DEPTH_LOG2 bytes
//   o_Empty      FIFO holds no bytes
//   o_Count      bytes currently queued (0..2**DEPTH_LOG2)
//   o_Overflow   sticky: a write was attempted while full
//   o_Tx_DV      one-cycle launch strobe to the transmitter
//   o_Tx_Byte    byte to the transmitter, held from launch to next launch
//   i_Tx_Active  transmitter busy flag
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Wr_En,
  input  logic [7:0]            i_Wr_Data,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Active
);

  localparam int                       DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]      DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]      CNT_ONE   = 1;
  localparam logic [DEPTH_LOG2-1:0]    PTR_ONE   = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACTIVE,
    S_WAIT_IDLE
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  wr_acc;
  logic                  pop;
  state_t                state;
  state_t                state_nxt;

  // A write is judged against the registered full flag, so a pop on the
  // same edge never makes room for it.
  assign wr_acc = i_Wr_En && !o_Full;

  always_comb begin
    count_nxt = o_Count;
    case ({wr_acc, pop})
      2'b10:   count_nxt = o_Count + CNT_ONE;
      2'b01:   count_nxt = o_Count - CNT_ONE;
      default: count_nxt = o_Count;
    endcase
  end

  // Storage carries data only, so it is not reset; validity is tracked by
  // the pointers and count.
  always_ff @(posedge i_Clock) begin
    if (wr_acc) begin
      mem[wr_ptr] <= i_Wr_Data;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Count    <= '0;
      o_Empty    <= 1'b1;
      o_Full     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (i_Wr_En && o_Full) begin
        o_Overflow <= 1'b1;
      end
      o_Count <= count_nxt;
      o_Empty <= (count_nxt == '0);
      o_Full  <= (count_nxt == DEPTH_CNT);
    end
  end

  // Launch sequencer: after each launch it waits to see the transmitter go
  // busy and then idle again, so a strobe is never issued into a busy line.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!o_Empty && !i_Tx_Active) begin
          pop       = 1'b1;
          state_nxt = S_WAIT_ACTIVE;
        end
      end
      S_WAIT_ACTIVE: begin
        if (i_Tx_Active) begin
          state_nxt = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (!i_Tx_Active) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_WAIT_IDLE;
    endcase
  end

  // Reset lands in S_WAIT_IDLE: the transmitter is not reset and may still
  // be mid-frame, so nothing is launched until it reports idle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state     <= S_WAIT_IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      state   <= state_nxt;
      o_Tx_DV <= pop;
      if (pop) begin
        o_Tx_Byte <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  localparam int PH_READY      = 0;
  localparam int PH_AWAIT_BUSY = 1;
  localparam int PH_AWAIT_IDLE = 2;

  logic          i_Clock = 1'b0;
  logic          i_Reset;
  logic          i_Wr_En;
  logic [7:0]    i_Wr_Data;
  logic          o_Full;
  logic          o_Empty;
  logic [DL:0]   o_Count;
  logic          o_Overflow;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;
  logic          i_Tx_Active;

  always #5 i_Clock = ~i_Clock;

  uart_tx_fifo #(.DEPTH_LOG2(DL)) uut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Wr_En     (i_Wr_En),
    .i_Wr_Data   (i_Wr_Data),
    .o_Full      (o_Full),
    .o_Empty     (o_Empty),
    .o_Count     (o_Count),
    .o_Overflow  (o_Overflow),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Active (i_Tx_Active)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: byte queue, sticky overflow, and the launch rule
  // "launch when ready, then require a busy period, then an idle sample".
  logic [7:0] q[$];
  bit         m_ovf;
  int         m_phase;
  bit         m_dv;
  logic [7:0] m_byte;
  bit         m_pop;

  // Transmitter model: busy starts one edge after it samples the strobe.
  bit         force_busy;
  int         busy_cnt;
  bit         dv_seen;
  int         frame_len;
  bit         rand_frames;

  logic [7:0] launches[$];
  int         max_count;

  task automatic step(input bit rst, input bit we, input logic [7:0] wd);
    bit full;
    bit act;
    @(negedge i_Clock);
    act         = force_busy || (busy_cnt != 0);
    i_Reset     = rst;
    i_Wr_En     = we;
    i_Wr_Data   = wd;
    i_Tx_Active = act;
    m_pop = 1'b0;
    if (rst) begin
      q.delete();
      m_ovf   = 1'b0;
      m_phase = PH_AWAIT_IDLE;
      m_dv    = 1'b0;
      m_byte  = 8'h00;
    end else begin
      full = (q.size() == DEPTH);
      if (m_phase == PH_READY && q.size() != 0 && !act) begin
        m_pop  = 1'b1;
        m_byte = q.pop_front();
      end
      m_dv = m_pop;
      if (we) begin
        if (full) m_ovf = 1'b1;
        else      q.push_back(wd);
      end
      case (m_phase)
        PH_READY:      if (m_pop) m_phase = PH_AWAIT_BUSY;
        PH_AWAIT_BUSY: if (act)   m_phase = PH_AWAIT_IDLE;
        default:       if (!act)  m_phase = PH_READY;
      endcase
    end
    @(posedge i_Clock);
    #1;
    check("count",    o_Count,    q.size());
    check("empty",    o_Empty,    q.size() == 0);
    check("full",     o_Full,     q.size() == DEPTH);
    check("overflow", o_Overflow, m_ovf);
    check("tx_dv",    o_Tx_DV,    m_dv);
    check("tx_byte",  o_Tx_Byte,  m_byte);
    if (o_Tx_DV) launches.push_back(o_Tx_Byte);
    if (int'(o_Count) > max_count) max_count = int'(o_Count);
    if (busy_cnt != 0) busy_cnt--;
    if (dv_seen) busy_cnt = rand_frames ? $urandom_range(1, 12) : frame_len;
    dv_seen = o_Tx_DV;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] sent[$];
  int         guard;
  bit         popped;
  logic [7:0] b;

  initial begin
    i_Reset = 1'b1; i_Wr_En = 1'b0; i_Wr_Data = 8'h00; i_Tx_Active = 1'b0;
    force_busy = 0; busy_cnt = 0; dv_seen = 0; frame_len = 6; rand_frames = 0;
    max_count = 0;

    // Reset state
    step(1'b1, 1'b0, 8'h00);
    check("rst_empty", o_Empty, 1);
    check("rst_count", o_Count, 0);
    check("rst_dv",    o_Tx_DV, 0);

    // 1: single byte into an empty FIFO with line idle
    idle(1);
    step(1'b0, 1'b1, 8'hA5);
    check("t1_no_same_edge", o_Tx_DV, 0);
    idle(1);
    check("t1_dv",   o_Tx_DV,   1);
    check("t1_byte", o_Tx_Byte, 8'hA5);
    idle(1);
    check("t1_dv_one_cycle", o_Tx_DV, 0);
    check("t1_empty",        o_Empty, 1);
    idle(20);

    // 2: fill while the transmitter is busy, then one more write
    force_busy = 1;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(i));
    check("t2_full",  o_Full,  1);
    check("t2_count", o_Count, DEPTH);
    step(1'b0, 1'b1, 8'hEE);
    check("t2_ovf",       o_Overflow, 1);
    check("t2_count_ovf", o_Count,    DEPTH);

    // 6: keep writing while full as the line frees up; the launch edge drops the write
    force_busy = 0;
    popped = 0;
    for (int i = 0; i < 8 && !popped; i++) begin
      step(1'b0, 1'b1, 8'($urandom));
      popped = m_pop;
    end
    check("t6_popped", popped,     1);
    check("t6_count",  o_Count,    DEPTH - 1);
    check("t6_ovf",    o_Overflow, 1);
    check("t6_head",   o_Tx_Byte,  8'h00);
    idle(200);

    // 3: three frames with a transmitter busy for ~10 bit times of 4 clocks
    frame_len = 42;
    step(1'b1, 1'b0, 8'h00);
    idle(1);
    launches.delete();
    step(1'b0, 1'b1, 8'h41);
    step(1'b0, 1'b1, 8'h42);
    step(1'b0, 1'b1, 8'h43);
    idle(200);
    check("t3_frames", launches.size(), 3);
    if (launches.size() == 3) begin
      check("t3_b0", launches[0], 8'h41);
      check("t3_b1", launches[1], 8'h42);
      check("t3_b2", launches[2], 8'h43);
    end

    // 4: 20 bytes across pointer wrap while draining
    frame_len = 3;
    step(1'b1, 1'b0, 8'h00);
    launches.delete(); sent.delete(); max_count = 0;
    guard = 0;
    while (sent.size() < 20 && guard < 400) begin
      guard++;
      if (q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        b = 8'($urandom);
        sent.push_back(b);
        step(1'b0, 1'b1, b);
      end else begin
        idle(1);
      end
    end
    idle(150);
    check("t4_sent",    sent.size(),     20);
    check("t4_emitted", launches.size(), 20);
    for (int i = 0; i < 20 && i < launches.size() && i < sent.size(); i++)
      check("t4_order", launches[i], sent[i]);
    check("t4_maxcnt_ok", max_count <= DEPTH, 1);
    check("t4_no_ovf",    o_Overflow,  0);

    // 5: reset mid-frame with 5 bytes queued
    frame_len = 40;
    step(1'b1, 1'b0, 8'h00);
    idle(1);
    step(1'b0, 1'b1, 8'h10);
    idle(4);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h20 + i));
    check("t5_queued", o_Count,     5);
    check("t5_busy",   i_Tx_Active, 1);
    step(1'b1, 1'b0, 8'h00);
    check("t5_flushed", o_Count, 0);
    launches.delete();
    step(1'b0, 1'b1, 8'h77);
    guard = 0;
    while (busy_cnt != 0 && guard < 100) begin
      guard++;
      idle(1);
      if (i_Tx_Active) check("t5_dv_held", o_Tx_DV, 0);
    end
    check("t5_line_freed", busy_cnt, 0);
    idle(10);
    check("t5_launch", launches.size(), 1);
    if (launches.size() == 1) check("t5_byte", launches[0], 8'h77);
    idle(60);

    // Random soak
    rand_frames = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 0) force_busy = ($urandom_range(0, 1) == 1);
      if (i % 300 == 40) force_busy = 0;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
